// File: rtl/dcache_mem_responder_pkg.sv
// Shared configuration, FSM state and request/response types for the cache's
// memory-side responder and its bench.
package dcache_mem_responder_pkg;

  localparam int          DC_XLEN            = 64;
  localparam int          DC_LINE_WIDTH      = 128;
  localparam int          DC_ADDR_WIDTH      = 64;
  localparam int          DC_MEM_WORDS       = 65536;
  localparam logic [63:0] DC_CACHED_ADDR_BEG = 64'h0000_0000_0001_0000;
  localparam int          DC_WORDS_PER_LINE  = DC_LINE_WIDTH / DC_XLEN;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EXEC,
    ST_RESP
  } rsp_state_e;

  typedef struct packed {
    logic                     we;
    logic                     line;
    logic [DC_ADDR_WIDTH-1:0] addr;
    logic [DC_XLEN/8-1:0]     be;
    logic [DC_LINE_WIDTH-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [DC_LINE_WIDTH-1:0] rdata;
    logic                     err;
  } mem_rsp_t;

endpackage

// File: rtl/dcache_mem_array.sv
// Single-port word array with per-byte write enables and a registered read port.
// Each byte lane is its own array so every lane maps cleanly onto block RAM.
module dcache_mem_array #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [WIDTH/8-1:0] be_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  output logic [WIDTH-1:0]   rdata_o
);

  for (genvar gi = 0; gi < WIDTH / 8; gi++) begin : g_byte
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
      if (en_i) begin
        if (we_i) begin
          if (be_i[gi]) begin
            mem_q[addr_i] <= wdata_i[gi*8 +: 8];
          end
        end else begin
          rdata_q <= mem_q[addr_i];
        end
      end
    end

    assign rdata_o[gi*8 +: 8] = rdata_q;
  end

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the write-back data cache: one request at a time,
// serviced from a word-interleaved array after a programmable latency.
module dcache_mem_responder
  import dcache_mem_responder_pkg::*;
#(
  parameter int                    XLEN            = DC_XLEN,
  parameter int                    LINE_WIDTH      = DC_LINE_WIDTH,
  parameter int                    ADDR_WIDTH      = DC_ADDR_WIDTH,
  parameter int                    MEM_WORDS       = DC_MEM_WORDS,
  parameter logic [ADDR_WIDTH-1:0] CACHED_ADDR_BEG = ADDR_WIDTH'(DC_CACHED_ADDR_BEG),
  parameter int                    LATENCY         = 4,
  parameter int                    CNT_WIDTH       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic                  req_line_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [XLEN/8-1:0]     req_be_i,
  input  logic [LINE_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [LINE_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [CNT_WIDTH-1:0]  rd_cnt_o,
  output logic [CNT_WIDTH-1:0]  wr_cnt_o
);

  localparam int WPL        = LINE_WIDTH / XLEN;
  localparam int OFF_W      = $clog2(XLEN / 8);
  localparam int LANE_W     = $clog2(WPL);
  localparam int LINE_OFF_W = OFF_W + LANE_W;
  localparam int IDX_W      = ADDR_WIDTH - OFF_W;
  localparam int BANK_DEPTH = MEM_WORDS / WPL;
  localparam int ROW_W      = $clog2(BANK_DEPTH);
  localparam int LAT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [IDX_W-1:0] MEM_WORDS_IDX = IDX_W'(MEM_WORDS);
  localparam logic [LAT_W-1:0] LAT_LOAD      = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  rsp_state_e           state_q, state_d;
  mem_req_t             req_q, req_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [WPL-1:0]       lane_en_q, lane_en_d;
  logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;

  logic [IDX_W-1:0]      word_idx;
  logic [IDX_W-1:0]      line_last_idx;
  logic [LANE_W-1:0]     lane;
  logic [ROW_W-1:0]      row;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic                  acc_err;
  logic                  exec_fire;
  logic                  unused_addr_lsbs;
  logic [XLEN-1:0]       bank_rdata [WPL];
  logic [LINE_WIDTH-1:0] rdata_mux;
  mem_rsp_t              rsp;

  // Word k of a line lives in bank k, so a whole line is one row across all banks.
  assign word_idx         = req_q.addr[ADDR_WIDTH-1:OFF_W];
  assign lane             = word_idx[LANE_W-1:0];
  assign row              = word_idx[LANE_W +: ROW_W];
  assign line_addr        = {req_q.addr[ADDR_WIDTH-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  assign line_last_idx    = {word_idx[IDX_W-1:LANE_W], {LANE_W{1'b1}}};
  assign unused_addr_lsbs = ^req_q.addr[OFF_W-1:0];

  always_comb begin
    if (req_q.line) begin
      acc_err = (line_addr < CACHED_ADDR_BEG) || (line_last_idx >= MEM_WORDS_IDX);
    end else begin
      acc_err = (word_idx >= MEM_WORDS_IDX);
    end
  end

  // A reset landing on the EXEC edge must not commit the write.
  assign exec_fire = (state_q == ST_EXEC) && !acc_err && !rst_i;

  for (genvar gi = 0; gi < WPL; gi++) begin : g_bank
    logic bank_sel;
    assign bank_sel = req_q.line || (lane == LANE_W'(gi));

    dcache_mem_array #(
      .WIDTH (XLEN),
      .DEPTH (BANK_DEPTH)
    ) u_bank (
      .clk_i   (clk_i),
      .en_i    (exec_fire && bank_sel),
      .we_i    (req_q.we),
      .be_i    (req_q.line ? {(XLEN/8){1'b1}} : req_q.be),
      .addr_i  (row),
      .wdata_i (req_q.wdata[gi*XLEN +: XLEN]),
      .rdata_o (bank_rdata[gi])
    );

    assign rdata_mux[gi*XLEN +: XLEN] = lane_en_q[gi] ? bank_rdata[gi] : '0;
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    lat_cnt_d = lat_cnt_q;
    rsp_err_d = rsp_err_q;
    lane_en_d = lane_en_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          req_d = '{we:    req_we_i,
                    line:  req_line_i,
                    addr:  req_addr_i,
                    be:    req_be_i,
                    wdata: req_wdata_i};
          lat_cnt_d = LAT_LOAD;
          state_d   = (LATENCY > 0) ? ST_WAIT : ST_EXEC;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = ST_EXEC;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      ST_EXEC: begin
        rsp_err_d = acc_err;
        if (acc_err || req_q.we) begin
          lane_en_d = '0;
        end else if (req_q.line) begin
          lane_en_d = '1;
        end else begin
          lane_en_d = WPL'(1) << lane;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d   = ST_IDLE;
          rsp_err_d = 1'b0;
          lane_en_d = '0;
          if (req_q.we) begin
            if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
          end else begin
            if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      lat_cnt_q   <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      lane_en_q   <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      lat_cnt_q   <= lat_cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      lane_en_q   <= lane_en_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign rsp         = '{rdata: rdata_mux, err: rsp_err_q};
  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp.rdata;
  assign rsp_err_o   = rsp.err;
  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench for dcache_mem_responder: one instance at LATENCY=4 for the
// functional scenarios, one at LATENCY=0 for back-to-back throughput.
module tb_dcache_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst4, v4, rdy4, we4, line4, rv4, rr4, err4;
  logic [63:0]  addr4;
  logic [7:0]   be4;
  logic [127:0] wd4, rd4;
  logic [31:0]  rc4, wc4;

  logic         rst0, v0, rdy0, we0, line0, rv0, rr0, err0;
  logic [63:0]  addr0;
  logic [7:0]   be0;
  logic [127:0] wd0, rd0;
  logic [31:0]  rc0, wc0;

  int n_cmp = 0;
  int n_bad = 0;

  dcache_mem_responder #(.LATENCY(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst4), .req_valid_i(v4), .req_ready_o(rdy4), .req_we_i(we4),
    .req_line_i(line4), .req_addr_i(addr4), .req_be_i(be4), .req_wdata_i(wd4),
    .rsp_valid_o(rv4), .rsp_ready_i(rr4), .rsp_rdata_o(rd4), .rsp_err_o(err4),
    .rd_cnt_o(rc4), .wr_cnt_o(wc4)
  );

  dcache_mem_responder #(.LATENCY(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst0), .req_valid_i(v0), .req_ready_o(rdy0), .req_we_i(we0),
    .req_line_i(line0), .req_addr_i(addr0), .req_be_i(be0), .req_wdata_i(wd0),
    .rsp_valid_o(rv0), .rsp_ready_i(rr0), .rsp_rdata_o(rd0), .rsp_err_o(err0),
    .rd_cnt_o(rc0), .wr_cnt_o(wc0)
  );

  // Drives one request into the LATENCY=4 instance; lat counts cycles from accept to rsp_valid.
  task automatic xact4(input logic we, input logic line, input logic [63:0] addr,
                       input logic [7:0] be, input logic [127:0] wdata,
                       output logic [127:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    v4 = 1'b1; we4 = we; line4 = line; addr4 = addr; be4 = be; wd4 = wdata;
    n = 0;
    while (rdy4 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    v4 = 1'b0;
    lat = 1;
    while (rv4 !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    rdata = rd4;
    err = err4;
    rr4 = 1'b1;
    @(negedge clk);
    rr4 = 1'b0;
    $display("xact we=%0b line=%0b addr=%h be=%h lat=%0d err=%0b rdata=%h",
             we, line, addr, be, lat, err, rdata);
  endtask

  function automatic logic [63:0] b2b_word(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  task automatic test_reset();
    rst4 = 1'b1; rst0 = 1'b1;
    repeat (3) @(negedge clk);
    rst4 = 1'b0; rst0 = 1'b0;
    n_cmp++; if (rdy4 !== 1'b1) begin n_bad++; $display("FAIL reset_ready4: got %b want 1", rdy4); end
    n_cmp++; if (rv4 !== 1'b0) begin n_bad++; $display("FAIL reset_valid4: got %b want 0", rv4); end
    n_cmp++; if (rd4 !== 128'h0) begin n_bad++; $display("FAIL reset_rdata4: got %h want 0", rd4); end
    n_cmp++; if (err4 !== 1'b0) begin n_bad++; $display("FAIL reset_err4: got %b want 0", err4); end
    n_cmp++; if (rc4 !== 32'h0) begin n_bad++; $display("FAIL reset_rdcnt4: got %0d want 0", rc4); end
    n_cmp++; if (wc4 !== 32'h0) begin n_bad++; $display("FAIL reset_wrcnt4: got %0d want 0", wc4); end
    n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL reset_ready0: got %b want 1", rdy0); end
    n_cmp++; if (rv0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid0: got %b want 0", rv0); end
  endtask

  task automatic test_word_write_line_read();
    logic [127:0] rd; logic er; int lat;
    xact4(1'b1, 1'b0, 64'h10000, 8'hFF, {64'h0, 64'hDEADBEEF_CAFEF00D}, rd, er, lat);
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL wwr_latency: got %0d want 6", lat); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL wwr_err: got %b want 0", er); end
    n_cmp++; if (rd !== 128'h0) begin n_bad++; $display("FAIL wwr_rdata: got %h want 0", rd); end
    xact4(1'b0, 1'b1, 64'h10000, 8'h00, 128'h0, rd, er, lat);
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL lrd_latency: got %0d want 6", lat); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL lrd_err: got %b want 0", er); end
    n_cmp++; if (rd[63:0] !== 64'hDEADBEEF_CAFEF00D)
      begin n_bad++; $display("FAIL lrd_data: got %h want deadbeefcafef00d", rd[63:0]); end
  endtask

  task automatic test_line_write_word_read();
    logic [127:0] rd; logic er; int lat;
    xact4(1'b1, 1'b1, 64'h20010, 8'h00,
          {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL lwr_err: got %b want 0", er); end
    xact4(1'b0, 1'b0, 64'h20018, 8'hFF, 128'h0, rd, er, lat);
    n_cmp++; if (rd !== {64'h2222_2222_2222_2222, 64'h0})
      begin n_bad++; $display("FAIL wrd_lane1: got %h want 2222222222222222_0000000000000000", rd); end
    xact4(1'b0, 1'b0, 64'h20010, 8'hFF, 128'h0, rd, er, lat);
    n_cmp++; if (rd !== {64'h0, 64'h1111_1111_1111_1111})
      begin n_bad++; $display("FAIL wrd_lane0: got %h want 0000000000000000_1111111111111111", rd); end
  endtask

  task automatic test_byte_enable();
    logic [127:0] rd; logic er; int lat;
    xact4(1'b1, 1'b0, 64'h20000, 8'hFF, 128'h0, rd, er, lat);
    xact4(1'b1, 1'b0, 64'h20000, 8'h0F, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFFFFFF_AAAAAAAA}, rd, er, lat);
    xact4(1'b0, 1'b0, 64'h20000, 8'hFF, 128'h0, rd, er, lat);
    n_cmp++; if (rd !== {64'h0, 64'h00000000_AAAAAAAA})
      begin n_bad++; $display("FAIL be_partial: got %h want 00000000aaaaaaaa in lane0", rd); end
    xact4(1'b1, 1'b0, 64'h20000, 8'h00, {128{1'b1}}, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL be_zero_err: got %b want 0", er); end
    xact4(1'b0, 1'b0, 64'h20000, 8'hFF, 128'h0, rd, er, lat);
    n_cmp++; if (rd !== {64'h0, 64'h00000000_AAAAAAAA})
      begin n_bad++; $display("FAIL be_zero_noop: got %h want 00000000aaaaaaaa in lane0", rd); end
  endtask

  task automatic test_errors();
    logic [127:0] rd; logic er; int lat; logic [31:0] rc_base, wc_base;
    rc_base = rc4;
    xact4(1'b0, 1'b1, 64'h100, 8'h00, 128'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL noncache_line_err: got %b want 1", er); end
    n_cmp++; if (rd !== 128'h0) begin n_bad++; $display("FAIL noncache_line_rdata: got %h want 0", rd); end
    xact4(1'b0, 1'b1, 64'h80000, 8'h00, 128'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL oor_line_err: got %b want 1", er); end
    n_cmp++; if (rd !== 128'h0) begin n_bad++; $display("FAIL oor_line_rdata: got %h want 0", rd); end
    n_cmp++; if ((rc4 - rc_base) !== 32'd2)
      begin n_bad++; $display("FAIL err_rdcnt_delta: got %0d want 2", rc4 - rc_base); end
    xact4(1'b0, 1'b0, 64'h100, 8'hFF, 128'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL noncache_word_err: got %b want 0", er); end
    wc_base = wc4;
    xact4(1'b1, 1'b0, 64'h80000, 8'hFF, {128{1'b1}}, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL oor_word_err: got %b want 1", er); end
    n_cmp++; if ((wc4 - wc_base) !== 32'd1)
      begin n_bad++; $display("FAIL err_wrcnt_delta: got %0d want 1", wc4 - wc_base); end
    xact4(1'b1, 1'b1, 64'h7FFF0, 8'h00, {64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000}, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL top_line_wr_err: got %b want 0", er); end
    xact4(1'b0, 1'b1, 64'h7FFF0, 8'h00, 128'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b0 || rd !== {64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000})
      begin n_bad++; $display("FAIL top_line_rd: got err=%b %h want err=0 7777000000000001_7777000000000000", er, rd); end
  endtask

  task automatic run_b2b0(input logic we);
    int acc_cyc [8];
    int k, r, cyc;
    logic [127:0] exp;
    k = 0; r = 0; cyc = 0;
    @(negedge clk);
    rr0 = 1'b1; we0 = we; line0 = 1'b0; be0 = 8'hFF;
    addr0 = 64'h40000; wd0 = {b2b_word(0), b2b_word(0)}; v0 = 1'b1;
    while (r < 8 && cyc < 60) begin
      if (rv0 === 1'b1) begin
        if (we) exp = 128'h0;
        else if (r % 2 == 1) exp = {b2b_word(r), 64'h0};
        else exp = {64'h0, b2b_word(r)};
        $display("b2b we=%0b idx=%0d cyc=%0d err=%0b rdata=%h", we, r, cyc, err0, rd0);
        n_cmp++; if (r >= k || cyc != acc_cyc[r] + 2)
          begin n_bad++; $display("FAIL b2b_latency idx=%0d: got rsp at cyc %0d want accept+2", r, cyc); end
        n_cmp++; if (rd0 !== exp || err0 !== 1'b0)
          begin n_bad++; $display("FAIL b2b_data idx=%0d: got err=%b %h want err=0 %h", r, err0, rd0, exp); end
        r++;
      end
      if (v0 === 1'b1 && rdy0 === 1'b1 && k < 8) begin
        acc_cyc[k] = cyc;
        if (k > 0) begin
          n_cmp++; if (acc_cyc[k] - acc_cyc[k-1] != 3)
            begin n_bad++; $display("FAIL b2b_accept_gap idx=%0d: got %0d want 3", k, acc_cyc[k] - acc_cyc[k-1]); end
        end
        k++;
        @(posedge clk); #1;
        if (k < 8) begin
          addr0 = 64'h40000 + 64'(8 * k);
          wd0 = {b2b_word(k), b2b_word(k)};
        end else begin
          v0 = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (r != 8) begin n_bad++; $display("FAIL b2b_count: got %0d responses want 8", r); end
    v0 = 1'b0; rr0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_b2b0(1'b1);
    run_b2b0(1'b0);
    n_cmp++; if (rc0 !== 32'd8) begin n_bad++; $display("FAIL b2b_rdcnt: got %0d want 8", rc0); end
    n_cmp++; if (wc0 !== 32'd8) begin n_bad++; $display("FAIL b2b_wrcnt: got %0d want 8", wc0); end
  endtask

  task automatic test_reset_during_wait();
    logic [127:0] rd; logic er; int lat; logic saw_valid;
    xact4(1'b1, 1'b1, 64'h30000, 8'h00, {64'hB1B1_B1B1_B1B1_B1B1, 64'hA1A1_A1A1_A1A1_A1A1}, rd, er, lat);
    @(negedge clk);
    v4 = 1'b1; we4 = 1'b1; line4 = 1'b1; addr4 = 64'h30000; be4 = 8'h00; wd4 = {128{1'b1}};
    @(negedge clk);
    v4 = 1'b0;
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    $display("reset asserted during WAIT of line write 0x30000");
    n_cmp++; if (rdy4 !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", rdy4); end
    n_cmp++; if (rc4 !== 32'h0 || wc4 !== 32'h0)
      begin n_bad++; $display("FAIL midrst_counters: got rd=%0d wr=%0d want 0 0", rc4, wc4); end
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rv4 !== 1'b0) saw_valid = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (saw_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_rsp: got valid=1 want 0"); end
    xact4(1'b0, 1'b1, 64'h30000, 8'h00, 128'h0, rd, er, lat);
    n_cmp++; if (rd !== {64'hB1B1_B1B1_B1B1_B1B1, 64'hA1A1_A1A1_A1A1_A1A1})
      begin n_bad++; $display("FAIL midrst_contents: got %h want b1b1b1b1b1b1b1b1_a1a1a1a1a1a1a1a1", rd); end
  endtask

  initial begin
    rst4 = 1'b1; v4 = 1'b0; we4 = 1'b0; line4 = 1'b0; addr4 = '0; be4 = '0; wd4 = '0; rr4 = 1'b0;
    rst0 = 1'b1; v0 = 1'b0; we0 = 1'b0; line0 = 1'b0; addr0 = '0; be0 = '0; wd0 = '0; rr0 = 1'b0;
    test_reset();
    test_word_write_line_read();
    test_line_write_word_read();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_reset_during_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Memory-side responder for the write-back data cache testbench; the other end of the cache's refill/writeback request channel.
- Accepts one request at a time: a line refill, a line writeback, or a single-word non-cacheable read/write.
- Services each request from an internal XLEN-word array after a programmable latency and returns a line-wide response.
- Enforces the cached/non-cacheable address split used by the cache configuration.

Parameters:
- XLEN, 64, data word width in bits
- LINE_WIDTH, 128, cache line width in bits; multiple of XLEN
- ADDR_WIDTH, 64, byte address width
- MEM_WORDS, 65536, array depth in XLEN words (512 KiB at defaults)
- CACHED_ADDR_BEG, 65536, byte address; addresses below are non-cacheable, addresses at or above are cacheable
- LATENCY, 4, wait cycles between accept and response; 0 allowed
- CNT_WIDTH, 32, statistics counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high together with valid
- req_we_i  in  1  1=write, 0=read
- req_line_i  in  1  1=full-line access, 0=single-word access
- req_addr_i  in  ADDR_WIDTH  byte address
- req_be_i  in  XLEN/8  byte enables, used for word writes only
- req_wdata_i  in  LINE_WIDTH  write data; a word write uses the lane selected by the address
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  LINE_WIDTH  read data
- rsp_err_o  out  1  access error
- rd_cnt_o  out  CNT_WIDTH  completed reads
- wr_cnt_o  out  CNT_WIDTH  completed writes

Behaviour:
- Clock and reset: single clock clk_i. Synchronous active-high rst_i.
- Reset values: FSM=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, counters=0. Array contents are not reset.
- FSM states:
  - IDLE: req_ready_o=1. On valid&ready, latch we/line/addr/be/wdata. Go to WAIT if LATENCY>0, else EXEC.
  - WAIT: req_ready_o=0. Counter loads LATENCY-1 on entry and decrements; at 0 go to EXEC.
  - EXEC: one cycle. Perform array access, register rdata/err, go to RESP.
  - RESP: rsp_valid_o=1, outputs held stable. On rsp_ready_i go to IDLE; a new request can be accepted the following cycle.
- Latency: accept at cycle t; rsp_valid_o rises at t+LATENCY+2.
- Line access:
  - Address aligned down to LINE_WIDTH/8.
  - Word k of the line is array[(addr>>log2(XLEN/8))+k], at rdata bits [k*XLEN +: XLEN].
  - req_be_i is ignored; writes are full-line.
- Word access:
  - Address aligned down to XLEN/8.
  - Lane = addr[log2(LINE_WIDTH/8)-1 : log2(XLEN/8)].
  - Read: word placed in its lane, other lanes 0.
  - Write: only bytes with be set are updated, data taken from that lane of wdata.
- Errors (rsp_err_o=1, no array write, rdata=0):
  - Word index ≥ MEM_WORDS, checked for every word of a line.
  - Line access with aligned address < CACHED_ADDR_BEG.
  - Word access with be=0 is not an error; it is a write no-op.
- Read response rdata equals the array contents at EXEC.
- Write response returns rdata=0, err per the rules above.
- Counters:
  - rd_cnt_o increments on each read handshake in RESP; wr_cnt_o on each write handshake.
  - Errored accesses also count.
  - Both saturate at all-ones.
- Boundary cases:
  - req_valid_i outside IDLE is ignored; the requester holds it.
  - rsp_ready_i held high continuously gives back-to-back service with one IDLE cycle between requests.
  - Reset during WAIT/EXEC/RESP returns to IDLE with rsp_valid_o=0 from the next cycle. A write is committed only if EXEC completed before the reset edge.
  - Highest line (last MEM_WORDS line) is legal; a line straddling the end is an error.

Decomposition:
- Shared testbench package: XLEN, LINE_WIDTH, MEM_WORDS, CACHED_ADDR_BEG constants derived from the cache configuration.
- Shared testbench package: responder FSM state enum.
- Shared testbench package: request struct {we, line, addr, be, wdata}.
- Shared testbench package: response struct {rdata, err}.
- One sub-module, dcache_mem_array: XLEN-wide single-port array with byte-enable write and synchronous read, instantiated for the storage.

Test Plan:
- LATENCY=4; word write addr 0x10000, be=0xFF, wdata lane0=0xDEADBEEF_CAFEF00D, then line read 0x10000 -> rdata[63:0]=0xDEADBEEF_CAFEF00D; each rsp_valid_o rises exactly 6 cycles after accept; err=0.
- Line write 0x20010 data {0x1111..., 0x2222...}, then word read 0x20018 -> rdata[127:64]=0x2222..., rdata[63:0]=0.
- Word write 0x20000 be=0x0F, data 0xFFFFFFFF_AAAAAAAA over 0x0 -> subsequent read returns 0x00000000_AAAAAAAA.
- Line read 0x100 (non-cacheable) -> err=1, rdata=0; line read at 0x80000 (out of range) -> err=1; rd_cnt_o increments by 2.
- LATENCY=0 with rsp_ready_i tied high, 8 back-to-back word reads -> each response 2 cycles after accept; req_ready_o high once every 3 cycles.
- Assert rst_i during WAIT of a line write to 0x30000 -> no response; line read of 0x30000 after reset returns the pre-write contents; counters are 0 after reset.
